// File: rtl/aes_rx_framer.sv
// UART 8N1 receiver that packs 16 received bytes into one 128-bit AES block.
// Ports: Clk, Rst (async active-low), Rx serial in, Block/Block_valid/Block_ready out-handshake, Frame_err/Overrun pulses.
module aes_rx_framer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Rx,
  output logic [127:0] Block,
  output logic         Block_valid,
  input  logic         Block_ready,
  output logic         Frame_err,
  output logic         Overrun
);

  localparam int CW     = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW     = $clog2(TO_CYC + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  state_e          state_q;
  logic            rx_s1_q;
  logic            rx_s2_q;
  logic            rxs_prev_q;
  logic            armed_q;
  logic [CW-1:0]   arm_cnt_q;
  logic [CW-1:0]   tmr_q;
  logic [2:0]      bit_q;
  logic [7:0]      sh_q;
  logic            done_q;
  logic            start_q;
  logic            ferr_q;

  logic [127:0]    blk_q, blk_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            vld_q, vld_d;
  logic            ovr_q, ovr_d;
  logic [TW-1:0]   idle_q, idle_d;

  logic            rxs;
  assign rxs = rx_s2_q;

  // Receiver: synchronizer, line arming and bit-level FSM.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= IDLE;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rxs_prev_q <= 1'b1;
      armed_q    <= 1'b0;
      arm_cnt_q  <= '0;
      tmr_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_s1_q    <= Rx;
      rx_s2_q    <= rx_s1_q;
      rxs_prev_q <= rxs;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
      ferr_q     <= 1'b0;

      // Once armed the line stays armed until a framing error.
      if (state_q == WAIT_HIGH) begin
        armed_q   <= 1'b0;
        arm_cnt_q <= '0;
      end else if (!armed_q) begin
        if (!rxs) begin
          arm_cnt_q <= '0;
        end else if (arm_cnt_q == BIT_LAST) begin
          armed_q <= 1'b1;
        end else begin
          arm_cnt_q <= arm_cnt_q + 1'b1;
        end
      end

      unique case (state_q)
        IDLE: begin
          if (armed_q && rxs_prev_q && !rxs) begin
            state_q <= START;
            tmr_q   <= '0;
            bit_q   <= '0;
            start_q <= 1'b1;
          end
        end
        START: begin
          if (tmr_q == HALF_LAST) begin
            tmr_q   <= '0;
            state_q <= rxs ? IDLE : DATA;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        DATA: begin
          if (tmr_q == BIT_LAST) begin
            tmr_q <= '0;
            sh_q  <= {rxs, sh_q[7:1]};
            if (bit_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        STOP: begin
          if (tmr_q == BIT_LAST) begin
            tmr_q <= '0;
            if (rxs) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_HIGH;
            end
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rxs) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Block assembly, output handshake and partial-block timeout.
  always_comb begin
    blk_d  = blk_q;
    cnt_d  = cnt_q;
    vld_d  = vld_q;
    ovr_d  = 1'b0;
    idle_d = idle_q;

    if (vld_q && Block_ready) begin
      vld_d = 1'b0;
    end

    if (start_q || cnt_q == 4'd0 || vld_q) begin
      idle_d = '0;
    end else if (idle_q != TO_LAST) begin
      idle_d = idle_q + 1'b1;
    end

    if (done_q) begin
      if (vld_q && !Block_ready) begin
        ovr_d = 1'b1;
      end else begin
        // {~n,3'b111} == 127 - 8*n for a 4-bit byte index.
        blk_d[{~cnt_q, 3'b111} -: 8] = sh_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == 4'd15) begin
          vld_d = 1'b1;
        end
      end
    end else if (idle_q == TO_LAST && cnt_q != 4'd0 && !vld_q) begin
      cnt_d  = '0;
      idle_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      blk_q  <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
      idle_q <= '0;
    end else begin
      blk_q  <= blk_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      ovr_q  <= ovr_d;
      idle_q <= idle_d;
    end
  end

  assign Block       = blk_q;
  assign Block_valid = vld_q;
  assign Frame_err   = ferr_q;
  assign Overrun     = ovr_q;

endmodule

// File: tb/tb_aes_rx_framer.sv
// Self-checking bench for aes_rx_framer: serial byte stimulus against a block-level model.
// Uses a short bit period so the whole run stays small.
module tb_aes_rx_framer;

  localparam int CPB = 16;
  localparam int TOB = 32;

  logic         clk;
  logic         rst_n;
  logic         rx;
  logic [127:0] block;
  logic         bvalid;
  logic         bready;
  logic         ferr;
  logic         ovr;

  aes_rx_framer #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .Clk        (clk),
    .Rst        (rst_n),
    .Rx         (rx),
    .Block      (block),
    .Block_valid(bvalid),
    .Block_ready(bready),
    .Frame_err  (ferr),
    .Overrun    (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int           fe_cnt, ov_cnt, run, run_max, rise_cyc, last_stop_cyc;
  logic         vld_prev;
  logic [127:0] got_q[$];
  logic [127:0] exp_q[$];
  logic [7:0]   m_bytes[$];

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ferr) fe_cnt++;
      if (ovr) ov_cnt++;
      if (bvalid && !vld_prev) rise_cyc = cyc;
      vld_prev = bvalid;
      if (bvalid) begin
        run++;
        if (run > run_max) run_max = run;
        if (bready) begin
          got_q.push_back(block);
          run = 0;
        end
      end else begin
        run = 0;
      end
    end else begin
      vld_prev = 1'b0;
      run = 0;
    end
  end

  // Model: good bytes fill a block MSB-first; 16 bytes make one block.
  task automatic m_push(input logic [7:0] b);
    logic [127:0] blk;
    m_bytes.push_back(b);
    if (m_bytes.size() == 16) begin
      blk = '0;
      foreach (m_bytes[i]) blk = {blk[119:0], m_bytes[i]};
      exp_q.push_back(blk);
      m_bytes.delete();
    end
  endtask

  task automatic clear_obs();
    fe_cnt = 0;
    ov_cnt = 0;
    run_max = 0;
    rise_cyc = 0;
    got_q.delete();
    exp_q.delete();
    m_bytes.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int gap);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    last_stop_cyc = cyc;
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (gap * CPB) @(negedge clk);
  endtask

  task automatic do_reset(input logic rx_lvl);
    @(negedge clk);
    rst_n = 1'b0;
    rx = rx_lvl;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    if (rx_lvl) repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    bready = 1'b1;
    rx = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (block !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_block got %h want 0", block);
    end
    n_chk++;
    if (bvalid !== 1'b0 || ferr !== 1'b0 || ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got v=%b fe=%b ov=%b want 0", bvalid, ferr, ovr);
    end
    // Line held low from reset must never start a frame.
    do_reset(1'b0);
    repeat (40 * CPB) @(negedge clk);
    n_chk++;
    if (fe_cnt !== 0 || bvalid !== 1'b0 || got_q.size() !== 0) begin
      n_fail++;
      $display("FAIL rx_low fe=%0d v=%b blocks=%0d want 0", fe_cnt, bvalid, got_q.size());
    end
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'(i * 17), 1'b1, 1);
    repeat (CPB) @(negedge clk);
    n_chk++;
    if (got_q.size() !== 1) begin
      n_fail++;
      $display("FAIL stream_count got %0d want 1", got_q.size());
    end else begin
      n_chk++;
      if (got_q[0] !== 128'h00112233445566778899aabbccddeeff) begin
        n_fail++;
        $display("FAIL stream_block got %h want 00112233445566778899aabbccddeeff", got_q[0]);
      end
    end
    n_chk++;
    if (run_max !== 1) begin
      n_fail++;
      $display("FAIL stream_valid_width got %0d want 1", run_max);
    end
    n_chk++;
    if (rise_cyc - last_stop_cyc < CPB / 2 || rise_cyc - last_stop_cyc > CPB) begin
      n_fail++;
      $display("FAIL stream_latency got %0d want %0d..%0d", rise_cyc - last_stop_cyc, CPB / 2, CPB);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       ok;
    int         nbad;
    do_reset(1'b1);
    nbad = 0;
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      if (ok) begin
        m_push(b);
        send_byte(b, 1'b1, $urandom_range(0, 3));
      end else begin
        nbad++;
        send_byte(b, 1'b0, 2 + $urandom_range(0, 1));
      end
    end
    repeat (CPB) @(negedge clk);
    n_chk++;
    if (fe_cnt !== nbad) begin
      n_fail++;
      $display("FAIL random_ferr got %0d want %0d", fe_cnt, nbad);
    end
    n_chk++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random_block%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] b;
    do_reset(1'b1);
    bready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      m_push(b);
      send_byte(b, 1'b1, 1);
    end
    send_byte(8'h5a, 1'b1, 1);
    n_chk++;
    if (ov_cnt !== 1) begin
      n_fail++;
      $display("FAIL overrun_pulses got %0d want 1", ov_cnt);
    end
    n_chk++;
    if (bvalid !== 1'b1 || block !== exp_q[0]) begin
      n_fail++;
      $display("FAIL overrun_hold got v=%b %h want v=1 %h", bvalid, block, exp_q[0]);
    end
    @(posedge clk);
    #1 bready = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (bvalid !== 1'b0 || got_q.size() !== 1) begin
      n_fail++;
      $display("FAIL overrun_release got v=%b n=%0d want v=0 n=1", bvalid, got_q.size());
    end
  endtask

  task automatic test_frame_err();
    logic [7:0] b;
    do_reset(1'b1);
    send_byte(8'h3c, 1'b0, 2);
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      m_push(b);
      send_byte(b, 1'b1, 0);
    end
    repeat (CPB) @(negedge clk);
    n_chk++;
    if (fe_cnt !== 1) begin
      n_fail++;
      $display("FAIL ferr_pulses got %0d want 1", fe_cnt);
    end
    n_chk++;
    if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL ferr_block got n=%0d want n=1 blk %h", got_q.size(), exp_q[0]);
    end
  endtask

  task automatic test_timeout();
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1, 1);
    send_byte(8'($urandom), 1'b1, 33);
    for (int i = 0; i < 16; i++) send_byte(8'ha5, 1'b1, 1);
    n_chk++;
    if (got_q.size() !== 1) begin
      n_fail++;
      $display("FAIL timeout_count got %0d want 1", got_q.size());
    end else begin
      n_chk++;
      if (got_q[0] !== {16{8'ha5}}) begin
        n_fail++;
        $display("FAIL timeout_block got %h want a5..a5", got_q[0]);
      end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] b;
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      m_push(b);
      send_byte(b, 1'b1, 1);
    end
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      b = 8'($urandom);
      m_push(b);
      send_byte(b, 1'b1, 1);
    end
    n_chk++;
    if (fe_cnt !== 0 || ov_cnt !== 0) begin
      n_fail++;
      $display("FAIL glitch_flags got fe=%0d ov=%0d want 0", fe_cnt, ov_cnt);
    end
    n_chk++;
    if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL glitch_block got n=%0d want n=1 blk %h", got_q.size(), exp_q[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    do_reset(1'b1);
    for (int i = 0; i < 32; i++) begin
      b = 8'($urandom);
      m_push(b);
      send_byte(b, 1'b1, 0);
    end
    repeat (CPB) @(negedge clk);
    n_chk++;
    if (got_q.size() !== 2) begin
      n_fail++;
      $display("FAIL b2b_count got %0d want 2", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_block%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    do_reset(1'b1);
    bready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b1, 1);
    n_chk++;
    if (bvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_fill got v=%b want 1", bvalid);
    end
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (bvalid !== 1'b0 || block !== 128'h0) begin
      n_fail++;
      $display("FAIL mid_async got v=%b %h want v=0 0", bvalid, block);
    end
    repeat (3) @(negedge clk);
    rx = 1'b1;
    rst_n = 1'b1;
    clear_obs();
    bready = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    n_chk++;
    if (fe_cnt !== 0 || ov_cnt !== 0 || got_q.size() !== 0) begin
      n_fail++;
      $display("FAIL mid_release got fe=%0d ov=%0d n=%0d want 0", fe_cnt, ov_cnt, got_q.size());
    end
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      m_push(b);
      send_byte(b, 1'b1, 1);
    end
    n_chk++;
    if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL mid_block got n=%0d want n=1 blk %h", got_q.size(), exp_q[0]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    bready = 1'b1;
    vld_prev = 1'b0;
    run = 0;
    last_stop_cyc = 0;
    clear_obs();
    test_reset();
    test_stream();
    test_random();
    test_overrun();
    bready = 1'b1;
    test_frame_err();
    test_timeout();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
